uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width; must equal the width of the upstream UART receiver's data output.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >= 2.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port rx_ready, input, 1 bit, UART receiver done level: rises at end of stop bit, held high until the next start bit.
REQ-006 SHALL have port rx_data, input, DATA_WIDTH bits, received byte; valid while rx_ready is high.
REQ-007 SHALL have port m_valid, output, 1 bit, head entry available.
REQ-008 SHALL have port m_data, output, DATA_WIDTH bits, head entry (show-ahead).
REQ-009 SHALL have port m_ready, input, 1 bit, consumer accepts head.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits, occupancy 0..DEPTH.
REQ-011 SHALL have port full, output, 1 bit, count == DEPTH.
REQ-012 SHALL have port empty, output, 1 bit, count == 0.
REQ-013 SHALL have port overflow, output, 1 bit, sticky drop flag; present only with UART_RX_FIFO_OVF_FLAG_EN.
REQ-014 SHALL have port ovf_clr, input, 1 bit, clears overflow; present only with UART_RX_FIFO_OVF_FLAG_EN.

Function
REQ-015 SHALL register rx_ready into rx_ready_d each cycle; push request = rx_ready & ~rx_ready_d (one push per received byte regardless of high duration).
REQ-016 SHALL write rx_data at wr_ptr on the same clock edge that samples the push request; m_valid high from the following cycle (1-cycle latency into an empty FIFO).
REQ-017 SHALL drive m_valid = ~empty and m_data = mem[rd_ptr]; m_data don't-care when empty.
REQ-018 SHALL pop when m_valid & m_ready, advancing rd_ptr at that edge; m_ready while empty is ignored.
REQ-019 SHALL, on push while not full, write the entry and advance wr_ptr.
REQ-020 SHALL, on push while full with a simultaneous pop, accept the push; count stays DEPTH.
REQ-021 SHALL, on push while full without a pop, drop the byte; memory, wr_ptr and count unchanged.
REQ-022 SHALL, on simultaneous push and pop when not full, leave count unchanged; both pointers advance.
REQ-023 SHALL wrap wr_ptr and rd_ptr modulo DEPTH; count increments on push-only, decrements on pop-only.
REQ-024 SHALL derive full, empty and m_valid from the count register only (no combinational path from m_ready or rx_ready).
REQ-025 SHALL hold data order strictly FIFO; no entry is ever lost except per REQ-021.

Reset
REQ-026 SHALL, while rst is high, force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, m_valid=0, overflow=0.
REQ-027 SHALL reset rx_ready_d to 1 so a receiver already holding rx_ready high cannot create a spurious push after reset; the first push follows its next low-to-high transition.
REQ-028 SHALL not reset memory contents; a reset mid-operation discards all stored bytes.

Configuration
REQ-029 SHALL, with macro UART_RX_FIFO_OVF_FLAG_EN defined, set overflow on any drop per REQ-021 and hold it until the cycle after ovf_clr=1; when set and clear coincide, set wins.
REQ-030 SHALL, without UART_RX_FIFO_OVF_FLAG_EN, omit the overflow and ovf_clr ports and drop bytes silently; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset, rx_ready pulsed 0->1 with rx_data=0xA5, m_ready=0 -> next cycle m_valid=1, m_data=0xA5, count=1.
REQ-032 SHALL cover: rx_ready held high 20 cycles for byte 0x3C -> exactly one entry, count=1.
REQ-033 SHALL cover: 16 bytes 0x00..0x0F pushed with m_ready=0 -> full=1, count=16; 17th byte 0xFF -> dropped, overflow=1; draining returns 0x00..0x0F in order, then empty=1.
REQ-034 SHALL cover: full FIFO, push 0x77 with m_ready=1 in the same cycle -> head popped, 0x77 stored, count stays 16, overflow stays 0.
REQ-035 SHALL cover: 40 bytes streamed with m_ready=1 -> pointer wrap occurs, all 40 values received in order, count never exceeds 1.
REQ-036 SHALL cover: rst asserted with count=5 and rx_ready high -> count=0, m_valid=0; rx_ready still high after release -> no push until the next 0->1 edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: one push per rising edge of rx_ready, show-ahead read port.
// Define UART_RX_FIFO_OVF_FLAG_EN to add the sticky overflow flag (overflow / ovf_clr ports).
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_ready,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  output logic                       m_valid,
  output logic [DATA_WIDTH-1:0]      m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
`ifdef UART_RX_FIFO_OVF_FLAG_EN
  ,
  output logic                       overflow,
  input  logic                       ovf_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_rx_ready_d;

  logic w_push, w_pop, w_full, w_empty, w_wr_en;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = rx_ready & ~r_rx_ready_d;
  assign w_pop   = ~w_empty & m_ready;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign w_wr_en = w_push & (~w_full | w_pop);

  assign m_valid = ~w_empty;
  assign m_data  = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= rx_data;
  end

  // rx_ready_d resets high so a level already asserted at reset release is not a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ready_d <= 1'b1;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_rx_ready_d <= rx_ready;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_en & ~w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop & ~w_wr_en) r_count <= r_count - 1'b1;
    end
  end

`ifdef UART_RX_FIFO_OVF_FLAG_EN
  logic w_drop;
  logic r_overflow;

  assign w_drop   = w_push & w_full & ~w_pop;
  assign overflow = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference, negedge monitor checks popped data.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] count;
  logic          full, empty;
`ifdef UART_RX_FIFO_OVF_FLAG_EN
  logic          overflow;
  logic          ovf_clr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  int            model_cnt;
  bit            prev_rr;
  bit            m_ovf;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .count(count), .full(full), .empty(empty)
`ifdef UART_RX_FIFO_OVF_FLAG_EN
    , .overflow(overflow), .ovf_clr(ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after posedge, so at negedge they show what the next edge consumes.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(m_data), 32'hdead);
      else                   chk("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  // Check current state against the model, then drive one cycle and advance the model.
  task automatic cyc(input bit rr, input logic [DW-1:0] d, input bit mr, input bit clr = 1'b0);
    bit push, pop, acc;
    chk("count", 32'(count), 32'(model_cnt));
    chk("empty", 32'(empty), 32'(model_cnt == 0));
    chk("full", 32'(full), 32'(model_cnt == DEPTH));
    chk("m_valid", 32'(m_valid), 32'(model_cnt != 0));
    if (model_cnt > 0) chk("head", 32'(m_data), 32'(exp_q[0]));
`ifdef UART_RX_FIFO_OVF_FLAG_EN
    chk("overflow", 32'(overflow), 32'(m_ovf));
    ovf_clr = clr;
`endif
    rx_ready = rr;
    rx_data  = d;
    m_ready  = mr;
    push = rr && !prev_rr;
    pop  = mr && (model_cnt > 0);
    acc  = push && (model_cnt < DEPTH || pop);
    if (acc) exp_q.push_back(d);
    model_cnt = model_cnt + int'(acc) - int'(pop);
    if (push && !acc) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    prev_rr = rr;
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [DW-1:0] d, input bit mr);
    cyc(1'b1, d, mr);
    cyc(1'b0, 8'h00, mr);
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b1);
  endtask

  // rx_ready is left at its current level to exercise the reset-time edge suppression.
  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    m_ovf = 1'b0;
    prev_rr = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
`ifdef UART_RX_FIFO_OVF_FLAG_EN
    chk("rst_overflow", 32'(overflow), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rx_ready = 1'b0;
    rx_data  = '0;
    m_ready  = 1'b0;
`ifdef UART_RX_FIFO_OVF_FLAG_EN
    ovf_clr  = 1'b0;
`endif
    do_reset();

    // single byte into an empty FIFO
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hA5, 1'b0);
    chk("a5_valid", 32'(m_valid), 32'd1);
    chk("a5_data", 32'(m_data), 32'hA5);
    chk("a5_count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    drain(2);

    // long rx_ready level counts once
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    repeat (20) cyc(1'b1, 8'h3C, 1'b0);
    chk("hold_count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    drain(3);

    // fill, drop, drain in order
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    push_byte(8'hFF, 1'b0);
    chk("drop_count", 32'(count), 32'd16);
`ifdef UART_RX_FIFO_OVF_FLAG_EN
    chk("drop_overflow", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
`endif
    drain(DEPTH + 2);
    chk("drain_empty", 32'(empty), 32'd1);

    // push into full FIFO with simultaneous pop
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b0);
    cyc(1'b1, 8'h77, 1'b1);
    chk("fullpop_count", 32'(count), 32'd16);
`ifdef UART_RX_FIFO_OVF_FLAG_EN
    chk("fullpop_overflow", 32'(overflow), 32'd0);
`endif
    cyc(1'b0, 8'h00, 1'b0);
    drain(DEPTH + 2);

    // streaming through the pointer wrap
    do_reset();
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) push_byte(8'(8'h40 + i), 1'b1);
    drain(2);

    // reset mid-operation with rx_ready held high
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) push_byte(8'(8'h50 + i), 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    do_reset();
    repeat (4) cyc(1'b1, 8'h66, 1'b0);
    chk("post_rst_count", 32'(count), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h67, 1'b0);
    chk("post_rst_push", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    drain(2);

    // random traffic: slow consumer, then fast consumer
    do_reset();
    repeat (800) cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 15) == 0));
    repeat (800) cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 15) == 0));
    drain(DEPTH + 2);
    chk("final_empty", 32'(empty), 32'd1);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
